// File: rtl/game_timer_ctrl.sv
// Run controller for the elapsed-time datapath: sequences idle/run/pause/over,
// gates divider and counter, tracks the best time and drives the display mux.
module game_timer_ctrl #(
    parameter int CNT_W      = 24,
    parameter int SHOW_TICKS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             pause_btn,
    input  logic             hit,
    input  logic             tick,
    input  logic [CNT_W-1:0] count,
    output logic             div_en,
    output logic             cnt_clr,
    output logic             cnt_inc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] disp,
    output logic [CNT_W-1:0] best,
    output logic             new_best
);

    localparam int SC_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SHOW_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_final;
    logic [CNT_W-1:0]  r_best;
    logic              r_new_best;
    logic [SC_W-1:0]   r_show_cnt;
    logic              r_show_sel;
    logic              r_start_q;
    logic              r_pause_q;
    logic              w_start_e;
    logic              w_pause_e;
    logic              w_enter_over;

    assign w_start_e    = start_btn & ~r_start_q;
    assign w_pause_e    = pause_btn & ~r_pause_q;
    assign w_enter_over = (r_state == S_RUN) && (w_next == S_OVER);

    assign state    = r_state;
    assign best     = r_best;
    assign new_best = r_new_best;

    always_comb begin
        w_next  = r_state;
        div_en  = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        disp    = count;
        case (r_state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                disp    = r_best;
                if (w_start_e) w_next = S_RUN;
            end
            S_RUN: begin
                div_en  = 1'b1;
                cnt_inc = tick & ~hit;
                // hit outranks saturation, which outranks a pause request
                if (hit)                          w_next = S_OVER;
                else if (tick && (count == '1))   w_next = S_OVER;
                else if (w_pause_e)               w_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_pause_e || w_start_e) w_next = S_RUN;
            end
            S_OVER: begin
                div_en = 1'b1;
                disp   = r_show_sel ? r_best : r_final;
                if (w_start_e) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_final    <= '0;
            r_best     <= '0;
            r_new_best <= 1'b0;
            r_show_cnt <= '0;
            r_show_sel <= 1'b0;
            r_start_q  <= 1'b0;
            r_pause_q  <= 1'b0;
        end else begin
            r_start_q <= start_btn;
            r_pause_q <= pause_btn;
            r_state   <= w_next;
            if (w_enter_over) begin
                r_final    <= count;
                r_show_cnt <= '0;
                r_show_sel <= 1'b0;
                if (count > r_best) begin
                    r_best     <= count;
                    r_new_best <= 1'b1;
                end else begin
                    r_new_best <= 1'b0;
                end
            end else if (r_state == S_OVER) begin
                if (w_start_e) r_new_best <= 1'b0;
                if (tick) begin
                    if (r_show_cnt == SC_LAST) begin
                        r_show_cnt <= '0;
                        r_show_sel <= ~r_show_sel;
                    end else begin
                        r_show_cnt <= r_show_cnt + SC_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed self-checking bench for game_timer_ctrl using immediate assertions.
module tb_game_timer_ctrl;

    localparam int CNT_W = 24;

    logic             clock = 1'b0;
    logic             reset;
    logic             start_btn;
    logic             pause_btn;
    logic             hit;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             div_en;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [1:0]       state;
    logic [CNT_W-1:0] disp;
    logic [CNT_W-1:0] best;
    logic             new_best;

    int tests = 0;
    int fails = 0;

    game_timer_ctrl #(.CNT_W(CNT_W), .SHOW_TICKS(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .hit      (hit),
        .tick     (tick),
        .count    (count),
        .div_en   (div_en),
        .cnt_clr  (cnt_clr),
        .cnt_inc  (cnt_inc),
        .state    (state),
        .disp     (disp),
        .best     (best),
        .new_best (new_best)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc();
        start_btn = 1'b0; cyc();
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    initial begin
        reset = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        hit = 1'b0; tick = 1'b0; count = '0;
        cyc(); cyc(); cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_best", 32'(best), 32'd0);
        chk("rst_newbest", 32'(new_best), 32'd0);
        chk("rst_diven", 32'(div_en), 32'd0);
        chk("rst_cntinc", 32'(cnt_inc), 32'd0);
        chk("rst_cntclr", 32'(cnt_clr), 32'd1);
        chk("rst_disp", 32'(disp), 32'd0);
        reset = 1'b1;
        cyc();
        chk("idle_stays", 32'(state), 32'd0);

        // held start gives exactly one edge
        start_btn = 1'b1;
        cyc();
        chk("start_run", 32'(state), 32'd1);
        chk("run_cntclr", 32'(cnt_clr), 32'd0);
        chk("run_diven", 32'(div_en), 32'd1);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("start_held_run", 32'(state), 32'd1);
        end
        start_btn = 1'b0;
        cyc();

        // pause / resume with count=5
        count = 24'd5;
        #1 chk("run_disp_count", 32'(disp), 32'd5);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_diven", 32'(div_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; #1;
            chk("pause_no_inc", 32'(cnt_inc), 32'd0);
            cyc();
            chk("pause_hold", 32'(state), 32'd2);
        end
        tick = 1'b0;
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        tick = 1'b1; #1;
        chk("resume_inc", 32'(cnt_inc), 32'd1);
        cyc(); tick = 1'b0;
        chk("resume_stay_run", 32'(state), 32'd1);

        // first game ends on hit coincident with tick at count=7
        count = 24'd7; hit = 1'b1; tick = 1'b1; #1;
        chk("hit_tick_no_inc", 32'(cnt_inc), 32'd0);
        cyc(); hit = 1'b0; tick = 1'b0;
        chk("g1_over", 32'(state), 32'd3);
        chk("g1_best", 32'(best), 32'd7);
        chk("g1_newbest", 32'(new_best), 32'd1);
        chk("g1_disp", 32'(disp), 32'd7);
        chk("over_diven", 32'(div_en), 32'd1);
        chk("over_cntinc", 32'(cnt_inc), 32'd0);
        press_start();
        chk("g1_idle", 32'(state), 32'd0);
        chk("g1_idle_newbest", 32'(new_best), 32'd0);
        chk("g1_idle_disp", 32'(disp), 32'd7);

        // second game ends at 3; display alternates 3/7 every 2 ticks
        press_start();
        chk("g2_run", 32'(state), 32'd1);
        count = 24'd3; hit = 1'b1; cyc(); hit = 1'b0;
        chk("g2_over", 32'(state), 32'd3);
        chk("g2_best", 32'(best), 32'd7);
        chk("g2_newbest", 32'(new_best), 32'd0);
        chk("g2_disp0", 32'(disp), 32'd3);
        pulse_tick(); chk("g2_disp1", 32'(disp), 32'd3);
        pulse_tick(); chk("g2_disp2", 32'(disp), 32'd7);
        pulse_tick(); chk("g2_disp3", 32'(disp), 32'd7);
        pulse_tick(); chk("g2_disp4", 32'(disp), 32'd3);
        pause_btn = 1'b1; hit = 1'b1; cyc(); pause_btn = 1'b0; hit = 1'b0;
        chk("over_ignore_pause", 32'(state), 32'd3);
        cyc();
        press_start();
        chk("g2_idle", 32'(state), 32'd0);
        chk("g2_idle_cntclr", 32'(cnt_clr), 32'd1);
        chk("g2_idle_disp", 32'(disp), 32'd7);

        // saturation ends the game
        press_start();
        count = 24'hFFFFFF; cyc();
        chk("sat_no_tick_run", 32'(state), 32'd1);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("sat_over", 32'(state), 32'd3);
        chk("sat_best", 32'(best), 32'hFFFFFF);
        chk("sat_final", 32'(disp), 32'hFFFFFF);
        chk("sat_newbest", 32'(new_best), 32'd1);
        press_start();

        // hit beats pause in the same cycle
        press_start();
        count = 24'd2; hit = 1'b1; pause_btn = 1'b1; cyc();
        hit = 1'b0; pause_btn = 1'b0;
        chk("hit_pause_over", 32'(state), 32'd3);
        chk("hit_pause_best", 32'(best), 32'hFFFFFF);
        chk("hit_pause_newbest", 32'(new_best), 32'd0);
        cyc();

        // reset during OVER with best=9
        reset = 1'b0; cyc(); reset = 1'b1; cyc();
        chk("rst2_best", 32'(best), 32'd0);
        press_start();
        count = 24'd9; hit = 1'b1; cyc(); hit = 1'b0;
        chk("g9_best", 32'(best), 32'd9);
        chk("g9_over", 32'(state), 32'd3);
        reset = 1'b0; start_btn = 1'b1; cyc();
        chk("rst_over_state", 32'(state), 32'd0);
        chk("rst_over_best", 32'(best), 32'd0);
        chk("rst_over_newbest", 32'(new_best), 32'd0);
        chk("rst_over_disp", 32'(disp), 32'd0);
        start_btn = 1'b0; cyc(); reset = 1'b1; cyc();
        chk("post_rst_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
